// File: rtl/frame_scan_reader_if.sv
// Frame scan reader bus: frame-buffer read port B, pixel FIFO
// write side, start pulse and status.
interface frame_scan_reader_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 24
);
    logic              start;
    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_data;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_din;
    logic              frame_done;
    logic              busy;

    modport master (
        input  start,
        input  fb_data,
        input  fifo_full,
        output fb_rd_en,
        output fb_addr,
        output fifo_wr_en,
        output fifo_din,
        output frame_done,
        output busy
    );

    modport slave (
        output start,
        output fb_data,
        output fifo_full,
        input  fb_rd_en,
        input  fb_addr,
        input  fifo_wr_en,
        input  fifo_din,
        input  frame_done,
        input  busy
    );
endinterface

// File: rtl/frame_scan_reader.sv
// Frame-buffer scanner: reads a H_SRC x V_SRC frame in raster order
// and pushes each pixel twice, each line twice, into the pixel FIFO.
module frame_scan_reader #(
    parameter int H_SRC  = 320,
    parameter int V_SRC  = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    frame_scan_reader_if.master   bus
);
    localparam int COL_W = (H_SRC > 1) ? $clog2(H_SRC) : 1;
    localparam int ROW_W = (V_SRC > 1) ? $clog2(V_SRC) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_SRC - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_SRC - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_SRC);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LAT,
        WR0,
        WR1
    } state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              rep_q, rep_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [DATA_W-1:0] pix_reg_q, pix_reg_d;
    logic              rd_en_q, rd_en_d;
    logic              busy_q, busy_d;
    logic              push;
    logic              frame_end;

    // Next-state, counter stepping and push qualification.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        rep_d       = rep_q;
        line_base_d = line_base_q;
        pix_reg_d   = pix_reg_q;
        frame_end   = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RD;
                end
            end
            RD: begin
                state_d = LAT;
            end
            LAT: begin
                pix_reg_d = bus.fb_data;
                state_d   = WR0;
            end
            WR0: begin
                push = !bus.fifo_full;
                if (push) begin
                    state_d = WR1;
                end
            end
            WR1: begin
                push = !bus.fifo_full;
                if (push) begin
                    state_d = RD;
                    if (col_q != COL_LAST) begin
                        col_d = col_q + COL_W'(1);
                    end else begin
                        col_d = '0;
                        if (!rep_q) begin
                            rep_d = 1'b1;
                        end else if (row_q != ROW_LAST) begin
                            rep_d       = 1'b0;
                            row_d       = row_q + ROW_W'(1);
                            line_base_d = line_base_q + LINE_STEP;
                        end else begin
                            frame_end   = 1'b1;
                            rep_d       = 1'b0;
                            row_d       = '0;
                            line_base_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rd_en_d = (state_d == RD);
        busy_d  = (state_d != IDLE);
    end

    // State, counters, pixel latch and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            rep_q       <= 1'b0;
            line_base_q <= '0;
            pix_reg_q   <= '0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rep_q       <= rep_d;
            line_base_q <= line_base_d;
            pix_reg_q   <= pix_reg_d;
            rd_en_q     <= rd_en_d;
            busy_q      <= busy_d;
        end
    end

    // Output drive; push and frame_done follow fifo_full directly.
    always_comb begin
        bus.fb_rd_en   = rd_en_q;
        bus.fb_addr    = line_base_q + ADDR_W'(col_q);
        bus.fifo_wr_en = push;
        bus.fifo_din   = pix_reg_q;
        bus.frame_done = frame_end;
        bus.busy       = busy_q;
    end
endmodule

// File: tb/tb_frame_scan_reader.sv
// Bench for frame_scan_reader on a 4x2 frame: cycle vector table,
// push-order model, backpressure, ignored start and reset cases.
module tb_frame_scan_reader;
    localparam int H = 4;
    localparam int V = 2;
    localparam int F = 4 * H * V;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    frame_scan_reader_if #(.ADDR_W(17), .DATA_W(24)) bus ();

    frame_scan_reader #(
        .H_SRC (H),
        .V_SRC (V),
        .ADDR_W(17),
        .DATA_W(24)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    // Frame-buffer model: data equals address, one cycle latency.
    always @(posedge clk) begin
        if (bus.fb_rd_en) bus.fb_data <= 24'(bus.fb_addr);
    end

    typedef struct {
        logic        start;
        logic        full;
        logic        rd;
        logic        wr;
        logic        busy;
        logic        fd;
        logic [16:0] addr;
        logic [23:0] din;
    } vec_t;

    vec_t vt[12];

    int checks = 0;
    int failures = 0;
    int k = 0;
    int rd_cnt = 0;
    int fd_cnt = 0;
    bit mon_en = 0;
    logic last_rd, last_wr, last_busy;
    logic [23:0] last_din;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", n, act, exp);
        end
    endtask

    function automatic int exp_addr(int kk);
        int m;
        m = kk % F;
        return (m / (4 * H)) * H + (m / 2) % H;
    endfunction

    task automatic step();
        @(negedge clk);
        last_rd   = bus.fb_rd_en;
        last_wr   = bus.fifo_wr_en;
        last_busy = bus.busy;
        last_din  = bus.fifo_din;
        if (bus.fb_rd_en) rd_cnt++;
        if (bus.frame_done) fd_cnt++;
        if (mon_en) begin
            if (bus.fifo_wr_en) begin
                chk("nofull", 32'(bus.fifo_full), 0);
                chk("din", 32'(bus.fifo_din), exp_addr(k));
                chk("fd_at_push", 32'(bus.frame_done),
                    32'((k % F) == F - 1));
                k++;
            end else if (bus.frame_done) begin
                chk("fd_stray", 32'(bus.frame_done), 0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(string n);
        chk({n, "_rd"}, 32'(bus.fb_rd_en), 0);
        chk({n, "_wr"}, 32'(bus.fifo_wr_en), 0);
        chk({n, "_fd"}, 32'(bus.frame_done), 0);
        chk({n, "_busy"}, 32'(bus.busy), 0);
        chk({n, "_addr"}, 32'(bus.fb_addr), 0);
        chk({n, "_din"}, 32'(bus.fifo_din), 0);
    endtask

    initial begin
        int n;
        int k0;
        vt[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 0, 1, 0, 1, 0, 0, 0};
        vt[2]  = '{0, 0, 0, 0, 1, 0, 0, 0};
        vt[3]  = '{0, 1, 0, 0, 1, 0, 0, 0};
        vt[4]  = '{0, 0, 0, 1, 1, 0, 0, 0};
        vt[5]  = '{0, 0, 0, 1, 1, 0, 0, 0};
        vt[6]  = '{0, 0, 1, 0, 1, 0, 1, 0};
        vt[7]  = '{0, 0, 0, 0, 1, 0, 1, 0};
        vt[8]  = '{0, 0, 0, 1, 1, 0, 1, 1};
        vt[9]  = '{0, 1, 0, 0, 1, 0, 1, 1};
        vt[10] = '{1, 0, 0, 1, 1, 0, 1, 1};
        vt[11] = '{0, 0, 1, 0, 1, 0, 2, 1};

        bus.start     = 1'b0;
        bus.fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            bus.start     = vt[i].start;
            bus.fifo_full = vt[i].full;
            @(negedge clk);
            chk($sformatf("v%0d_rd", i), 32'(bus.fb_rd_en), 32'(vt[i].rd));
            chk($sformatf("v%0d_wr", i), 32'(bus.fifo_wr_en), 32'(vt[i].wr));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vt[i].busy));
            chk($sformatf("v%0d_fd", i), 32'(bus.frame_done), 32'(vt[i].fd));
            chk($sformatf("v%0d_addr", i), 32'(bus.fb_addr), 32'(vt[i].addr));
            if (vt[i].wr)
                chk($sformatf("v%0d_din", i), 32'(bus.fifo_din),
                    32'(vt[i].din));
            @(posedge clk);
            #1;
        end
        bus.start     = 1'b0;
        bus.fifo_full = 1'b0;

        k      = 4;
        fd_cnt = 0;
        mon_en = 1;
        n = 0;
        while (k < F + 8 && n < 400) begin
            step();
            n++;
        end
        chk("frame1_done", 32'(k >= F + 8), 1);
        chk("frame1_fd_cnt", fd_cnt, 1);

        n = 0;
        do begin
            step();
            n++;
        end while (!last_rd && n < 20);
        chk("hold_sync", 32'(last_rd), 1);
        bus.fifo_full = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_wr", 32'(last_wr), 0);
            chk("hold_din", 32'(last_din), exp_addr(k));
        end
        chk("hold_busy", 32'(last_busy), 1);
        k0 = k;
        bus.fifo_full = 1'b0;
        n = 0;
        while (k < k0 + 2 && n < 20) begin
            step();
            n++;
        end
        chk("hold_release", 32'(k == k0 + 2), 1);

        n = 0;
        while ((k % F) != 0 && n < 400) begin
            step();
            n++;
        end
        chk("align", k % F, 0);
        k0     = k;
        fd_cnt = 0;
        rd_cnt = 0;
        n = 0;
        while (fd_cnt == 0 && n < 2000) begin
            bus.fifo_full = 1'($urandom_range(0, 1));
            bus.start     = ($urandom_range(0, 7) == 0);
            step();
            n++;
        end
        bus.fifo_full = 1'b0;
        bus.start     = 1'b0;
        chk("rand_pushes", k - k0, F);
        chk("rand_fd_cnt", fd_cnt, 1);
        chk("rand_rd_cnt", rd_cnt, H * V * 2);

        n = 0;
        while ((k % F) != 10 && n < 400) begin
            step();
            n++;
        end
        chk("mid_sync", k % F, 10);
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        chk_zero("async_rst");
        step();
        step();
        rst_n = 1'b1;
        k      = 0;
        mon_en = 1;
        for (int i = 0; i < 20; i++) step();
        chk("post_rst_pushes", k, 0);
        chk("post_rst_busy", 32'(last_busy), 0);
        chk("post_rst_rd", rd_cnt > 0 ? 32'(last_rd) : 0, 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        while (k < 12 && n < 200) begin
            step();
            n++;
        end
        chk("restart_pushes", 32'(k >= 12), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
